// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception controller: exception codes,
// CP0 register addresses, register field positions and the redirect FSM state.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_BEV   = 22;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_BD     = 31;

    // Bit positions inside the commit-stage exception vector.
    localparam int BIT_ADEL_IF = 5;
    localparam int BIT_RI      = 4;
    localparam int BIT_OV      = 3;
    localparam int BIT_SYS     = 2;
    localparam int BIT_BP      = 1;
    localparam int BIT_ADEM    = 0;

    localparam int TIMER_DIV_W = 2;

    typedef enum logic {
        S_IDLE,
        S_REDIR
    } exc_state_t;

    function automatic logic [4:0] exc_code(input logic       int_pend,
                                            input logic [5:0] exc,
                                            input logic       is_store);
        if (int_pend)              return EXC_INT;
        else if (exc[BIT_ADEL_IF]) return EXC_ADEL;
        else if (exc[BIT_RI])      return EXC_RI;
        else if (exc[BIT_OV])      return EXC_OV;
        else if (exc[BIT_SYS])     return EXC_SYS;
        else if (exc[BIT_BP])      return EXC_BP;
        else                       return is_store ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances once every COUNT_DIV clocks and
// raises a sticky timer interrupt (ti) when it meets a non-zero Compare.
module cp0_timer
    import exc_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [TIMER_DIV_W-1:0] div_q;
    logic                   tick;

    assign tick = (div_q == TIMER_DIV_W'(COUNT_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            div_q <= '0;
        end else if (count_we) begin
            count <= wdata;
            div_q <= '0;
        end else if (tick) begin
            count <= count + 32'd1;
            div_q <= '0;
        end else begin
            div_q <= div_q + TIMER_DIV_W'(1);
        end
    end

    // A Compare write wins over a coincident match so software can always clear TI.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (compare_we) begin
            compare <= wdata;
            ti      <= 1'b0;
        end else if ((count == compare) && (compare != 32'd0)) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller: takes traps and ERET at the commit stage
// and issues a one-cycle pipeline flush with the redirect target.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cm_valid,
    input  logic [31:0] cm_pc,
    input  logic        cm_in_ds,
    input  logic [5:0]  cm_exc,
    input  logic        cm_is_store,
    input  logic [31:0] cm_badaddr,
    input  logic        cm_eret,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_rdata,
    input  logic [5:0]  hw_int,
    output logic        flush,
    output logic [31:0] new_pc
);

    exc_state_t  state_q, state_d;
    logic [7:0]  status_im;
    logic        status_exl, status_ie;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [1:0]  cause_swip;
    logic [31:0] epc, badvaddr, redir_pc;
    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  cause_ip;
    logic        idle, int_pend, trap, eret, cp0_we;
    logic        bad_from_pc, bad_from_addr;
    logic [4:0]  trap_code;

    // Anything presented while redirecting belongs to a squashed instruction.
    assign idle     = (state_q == S_IDLE);
    assign cause_ip = {hw_int[5] | ti, hw_int[4:0], cause_swip};
    assign int_pend = (|(cause_ip & status_im)) & status_ie & ~status_exl;
    assign trap     = idle & cm_valid & (int_pend | (|cm_exc));
    assign eret     = idle & cm_valid & cm_eret & ~trap;
    assign cp0_we   = idle & mtc0_we & ~trap & ~eret;

    assign trap_code     = exc_code(int_pend, cm_exc, cm_is_store);
    assign bad_from_pc   = ~int_pend & cm_exc[BIT_ADEL_IF];
    assign bad_from_addr = ~int_pend & (cm_exc[5:1] == 5'd0) & cm_exc[BIT_ADEM];

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (cp0_we && (mtc0_addr == CP0_COUNT)),
        .compare_we (cp0_we && (mtc0_addr == CP0_COMPARE)),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trap || eret) state_d = S_REDIR;
            S_REDIR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush  = 1'b0;
        new_pc = '0;
        if (state_q == S_REDIR) begin
            flush  = 1'b1;
            new_pc = redir_pc;
        end
    end

    // A nested trap (EXL already set) must keep the original EPC and BD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
            cause_bd   <= 1'b0;
            cause_exc  <= '0;
            cause_swip <= '0;
            epc        <= '0;
            badvaddr   <= '0;
            redir_pc   <= '0;
        end else if (trap) begin
            if (!status_exl) begin
                epc      <= cm_in_ds ? cm_pc - 32'd4 : cm_pc;
                cause_bd <= cm_in_ds;
            end
            cause_exc  <= trap_code;
            status_exl <= 1'b1;
            redir_pc   <= EXC_VECTOR;
            if (bad_from_pc)        badvaddr <= cm_pc;
            else if (bad_from_addr) badvaddr <= cm_badaddr;
        end else if (eret) begin
            status_exl <= 1'b0;
            redir_pc   <= epc;
        end else if (cp0_we) begin
            case (mtc0_addr)
                CP0_STATUS: begin
                    status_im  <= mtc0_wdata[STATUS_IM_LO +: 8];
                    status_exl <= mtc0_wdata[STATUS_EXL];
                    status_ie  <= mtc0_wdata[STATUS_IE];
                end
                CP0_CAUSE: cause_swip <= mtc0_wdata[CAUSE_IP_LO +: 2];
                CP0_EPC:   epc        <= mtc0_wdata;
                default:   ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mfc0_rdata = '0;
        case (mfc0_addr)
            CP0_BADVADDR: mfc0_rdata = badvaddr;
            CP0_COUNT:    mfc0_rdata = count;
            CP0_COMPARE:  mfc0_rdata = compare;
            CP0_EPC:      mfc0_rdata = epc;
            CP0_STATUS: begin
                mfc0_rdata[STATUS_BEV]        = 1'b1;
                mfc0_rdata[STATUS_IM_LO +: 8] = status_im;
                mfc0_rdata[STATUS_EXL]        = status_exl;
                mfc0_rdata[STATUS_IE]         = status_ie;
            end
            CP0_CAUSE: begin
                mfc0_rdata[CAUSE_BD]          = cause_bd;
                mfc0_rdata[CAUSE_IP_LO +: 8]  = cause_ip;
                mfc0_rdata[CAUSE_EXC_LO +: 5] = cause_exc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic,
// compared against a behavioural CP0 model with a redirect scoreboard.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk, resetn;
    logic        cm_valid, cm_in_ds, cm_is_store, cm_eret;
    logic [31:0] cm_pc, cm_badaddr;
    logic [5:0]  cm_exc, hw_int;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr, mfc0_addr;
    logic [31:0] mtc0_wdata, mfc0_rdata;
    logic        flush;
    logic [31:0] new_pc;

    exc_ctrl #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .resetn(resetn),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_in_ds(cm_in_ds), .cm_exc(cm_exc),
        .cm_is_store(cm_is_store), .cm_badaddr(cm_badaddr), .cm_eret(cm_eret),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata), .hw_int(hw_int),
        .flush(flush), .new_pc(new_pc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    // Behavioural model of the architectural CP0 state.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_redir;
    logic [4:0]  m_exc;
    logic [1:0]  m_swip;
    logic [31:0] m_epc, m_bad, m_compare, m_count_base;
    int          m_since;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_redir = 0;
        m_exc = '0; m_swip = '0; m_epc = '0; m_bad = '0; m_compare = '0;
        m_count_base = '0; m_since = 0;
    endtask

    function automatic logic [31:0] m_count_now();
        return m_count_base + 32'(m_since / DIV);
    endfunction

    function automatic logic [7:0] m_ip();
        return {hw_int[5] | m_ti, hw_int[4:0], m_swip};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count_now();
            5'd11:   return m_compare;
            5'd12:   return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'd0, m_ip(), 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] m_code(input logic [5:0] e, input logic st);
        if (e[5]) return 5'h04;
        if (e[4]) return 5'h0A;
        if (e[3]) return 5'h0C;
        if (e[2]) return 5'h08;
        if (e[1]) return 5'h09;
        return st ? 5'h05 : 5'h04;
    endfunction

    // One clock: check the read port, apply the model's rules to the driven
    // inputs, let the edge happen, then check the flush output.
    task automatic cycle();
        logic [7:0]  ip;
        logic [31:0] cnt;
        logic        ipend, trap, eret, wr, ti_set, next_redir;
        #1;
        check("mfc0_rdata", mfc0_rdata, m_read(mfc0_addr));
        cnt        = m_count_now();
        ti_set     = (cnt == m_compare) && (m_compare != 32'd0);
        trap       = 0;
        eret       = 0;
        wr         = 0;
        next_redir = 0;
        if (!m_redir) begin
            ip    = m_ip();
            ipend = ((ip & m_im) != 8'd0) && m_ie && !m_exl;
            trap  = cm_valid && (ipend || (cm_exc != 6'd0));
            eret  = cm_valid && cm_eret && !trap;
            wr    = mtc0_we && !trap && !eret;
            if (trap) begin
                if (!m_exl) begin
                    m_epc = cm_in_ds ? cm_pc - 32'd4 : cm_pc;
                    m_bd  = cm_in_ds;
                end
                m_exc = ipend ? 5'h00 : m_code(cm_exc, cm_is_store);
                m_exl = 1;
                if (!ipend && cm_exc[5]) m_bad = cm_pc;
                else if (!ipend && cm_exc[5:1] == 5'd0 && cm_exc[0]) m_bad = cm_badaddr;
                exp_q.push_back(VEC);
                next_redir = 1;
            end else if (eret) begin
                exp_q.push_back(m_epc);
                m_exl = 0;
                next_redir = 1;
            end else if (wr) begin
                case (mtc0_addr)
                    5'd12: begin m_im = mtc0_wdata[15:8]; m_exl = mtc0_wdata[1]; m_ie = mtc0_wdata[0]; end
                    5'd13: m_swip = mtc0_wdata[9:8];
                    5'd14: m_epc = mtc0_wdata;
                    default: ;
                endcase
            end
        end
        if (wr && mtc0_addr == 5'd11) begin
            m_compare = mtc0_wdata;
            m_ti = 0;
        end else if (ti_set) begin
            m_ti = 1;
        end
        if (wr && mtc0_addr == 5'd9) begin
            m_count_base = mtc0_wdata;
            m_since = 0;
        end else begin
            m_since++;
        end
        m_redir = next_redir;
        @(posedge clk);
        #1;
        check("flush", {31'd0, flush}, {31'd0, m_redir});
        if (!m_redir) check("new_pc_idle", new_pc, 32'd0);
    endtask

    // Monitor: every redirect the DUT presents must match the next scoreboard entry.
    always @(negedge clk) begin
        if (resetn && flush) begin
            if (exp_q.size() == 0) check("flush_without_expect", {31'd0, flush}, 32'd0);
            else                   check("new_pc", new_pc, exp_q.pop_front());
        end
    end

    task automatic idle_inputs();
        cm_valid = 0; cm_pc = '0; cm_in_ds = 0; cm_exc = '0; cm_is_store = 0;
        cm_badaddr = '0; cm_eret = 0; mtc0_we = 0; mtc0_addr = '0; mtc0_wdata = '0;
        hw_int = '0;
    endtask

    task automatic peek(input string name, input logic [4:0] a, input logic [31:0] mask,
                        input logic [31:0] exp);
        mfc0_addr = a;
        #1;
        check(name, mfc0_rdata & mask, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we = 1; mtc0_addr = a; mtc0_wdata = d;
        cycle();
        mtc0_we = 0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic ds, input logic [5:0] exc,
                          input logic st, input logic [31:0] bad, input logic er);
        cm_valid = 1; cm_pc = pc; cm_in_ds = ds; cm_exc = exc; cm_is_store = st;
        cm_badaddr = bad; cm_eret = er;
        cycle();
        cm_valid = 0; cm_exc = '0; cm_eret = 0;
    endtask

    initial begin
        logic [4:0] addrs [7];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
        idle_inputs();
        mfc0_addr = 5'd12;
        resetn = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;

        // Reset state.
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        peek("rst_status", 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
        peek("rst_cause", 5'd13, 32'hFFFF_FFFF, 32'd0);
        peek("rst_epc", 5'd14, 32'hFFFF_FFFF, 32'd0);
        peek("rst_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'd0);
        peek("rst_compare", 5'd11, 32'hFFFF_FFFF, 32'd0);
        peek("unmapped_reg", 5'd20, 32'hFFFF_FFFF, 32'd0);

        // Overflow outside a delay slot.
        commit(32'hBFC0_0100, 0, 6'b001000, 0, '0, 0);
        check("ov_flush", {31'd0, flush}, 32'd1);
        cycle();
        peek("ov_epc", 5'd14, 32'hFFFF_FFFF, 32'hBFC0_0100);
        peek("ov_exccode", 5'd13, 32'h0000_007C, 32'h0C << 2);
        peek("ov_exl", 5'd12, 32'h0000_0002, 32'h2);
        commit('0, 0, 6'd0, 0, '0, 1);
        cycle();

        // Syscall in a delay slot, then ERET back to the branch.
        commit(32'hBFC0_0208, 1, 6'b000100, 0, '0, 0);
        cycle();
        peek("sys_epc", 5'd14, 32'hFFFF_FFFF, 32'hBFC0_0204);
        peek("sys_bd", 5'd13, 32'h8000_0000, 32'h8000_0000);
        commit('0, 0, 6'd0, 0, '0, 1);
        check("eret_new_pc", new_pc, 32'hBFC0_0204);
        cycle();
        peek("eret_exl", 5'd12, 32'h0000_0002, 32'h0);

        // Fetch address error beats reserved instruction.
        commit(32'h8000_0003, 0, 6'b110000, 0, 32'h1234_5678, 0);
        cycle();
        peek("adel_exccode", 5'd13, 32'h0000_007C, 32'h04 << 2);
        peek("adel_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'h8000_0003);
        commit('0, 0, 6'd0, 0, '0, 1);
        cycle();

        // Data store address error loads BadVAddr from the data address.
        commit(32'h0000_0040, 0, 6'b000001, 1, 32'hDEAD_BEE1, 0);
        cycle();
        peek("ades_exccode", 5'd13, 32'h0000_007C, 32'h05 << 2);
        peek("ades_badvaddr", 5'd8, 32'hFFFF_FFFF, 32'hDEAD_BEE1);
        commit('0, 0, 6'd0, 0, '0, 1);
        cycle();

        // Count wrap at the 32-bit boundary.
        mtc0(5'd9, 32'hFFFF_FFFF);
        cycle();
        cycle();
        peek("count_wrap", 5'd9, 32'hFFFF_FFFF, 32'd0);

        // Timer interrupt.
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 30 && !m_ti; i++) cycle();
        peek("ti_set", 5'd13, 32'h0000_8000, 32'h0000_8000);
        commit(32'h0000_0400, 0, 6'd0, 0, '0, 0);
        check("int_flush", {31'd0, flush}, 32'd1);
        cycle();
        peek("int_exccode", 5'd13, 32'h0000_007C, 32'd0);
        mtc0(5'd11, 32'd0);
        peek("ti_clear", 5'd13, 32'h0000_8000, 32'd0);
        commit('0, 0, 6'd0, 0, '0, 1);
        cycle();

        // Nested exception keeps EPC; reset during the redirect drops flush.
        commit(32'h0000_0100, 0, 6'b000010, 0, '0, 0);
        cycle();
        commit(32'h0000_0200, 0, 6'b010000, 0, '0, 0);
        cycle();
        peek("nested_epc", 5'd14, 32'hFFFF_FFFF, 32'h0000_0100);
        peek("nested_exccode", 5'd13, 32'h0000_007C, 32'h0A << 2);
        commit(32'h0000_0300, 0, 6'b001000, 0, '0, 0);
        check("pre_reset_flush", {31'd0, flush}, 32'd1);
        resetn = 0;
        #1;
        check("reset_drops_flush", {31'd0, flush}, 32'd0);
        check("reset_new_pc", new_pc, 32'd0);
        peek("reset_status", 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
        m_reset();
        exp_q.delete();
        @(negedge clk);
        resetn = 1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cm_valid    = ($urandom_range(0, 1) == 1);
            cm_pc       = $urandom;
            cm_in_ds    = ($urandom_range(0, 3) == 0);
            cm_exc      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            cm_is_store = ($urandom_range(0, 1) == 1);
            cm_badaddr  = $urandom;
            cm_eret     = ($urandom_range(0, 3) == 0);
            mtc0_we     = ($urandom_range(0, 2) == 0);
            mtc0_addr   = addrs[$urandom_range(0, 6)];
            mtc0_wdata  = $urandom;
            if (mtc0_addr == 5'd11 && $urandom_range(0, 1) == 1)
                mtc0_wdata = m_count_now() + 32'($urandom_range(1, 6));
            if (mtc0_addr == 5'd9 && $urandom_range(0, 3) == 0)
                mtc0_wdata = 32'hFFFF_FFFE;
            hw_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            mfc0_addr = addrs[$urandom_range(0, 6)];
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        check("pending_redirects", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
